// File: rtl/serial_transmitter_gen.sv
// Push-button driven serial frame transmitter: start bit, MSB-first length field, data bits,
// optional even parity, with a hex display of the remaining bit count.
module serial_transmitter_gen #(
    parameter int unsigned CNT_W       = 4,
    parameter bit          START_LEVEL = 1'b0,
    parameter bit          PARITY_EN   = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SerIn,
    input  logic       ClkPB,
    output logic       SerOut,
    output logic       SerOutValid,
    output logic       Done,
    output logic [6:0] seven_segments
);

    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {StIdle, StCount, StData, StParity} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   par_q, par_d;
    logic                   done_q, done_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic                   step;
    logic [7:0]             cnt_ext;
    logic [3:0]             nibble;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], ClkPB};
    assign step   = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        par_d   = par_q;
        done_d  = 1'b0;
        if (step) begin
            unique case (state_q)
                StIdle: begin
                    if (SerIn == START_LEVEL) begin
                        state_d = StCount;
                        cnt_d   = '0;
                        idx_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                StCount: begin
                    cnt_d = CNT_W'({cnt_q, SerIn});
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(CNT_W - 1)) begin
                        idx_d = '0;
                        if (cnt_d != '0) begin
                            state_d = StData;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                end
                StData: begin
                    par_d = par_q ^ SerIn;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        if (PARITY_EN) begin
                            state_d = StParity;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                end
                StParity: begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
            sync_q  <= '0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            done_q  <= done_d;
            sync_q  <= sync_d;
            prev_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // SerOut in DATA is a pass-through of SerIn, not a registered copy.
    always_comb begin
        SerOut      = 1'b0;
        SerOutValid = 1'b0;
        unique case (state_q)
            StData: begin
                SerOut      = SerIn;
                SerOutValid = 1'b1;
            end
            StParity: begin
                SerOut      = par_q;
                SerOutValid = 1'b1;
            end
            default: begin
                SerOut      = 1'b0;
                SerOutValid = 1'b0;
            end
        endcase
    end

    assign Done    = done_q;
    assign cnt_ext = 8'(cnt_q);
    assign nibble  = cnt_ext[3:0];

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        seven_segments = 7'b1111111;
        unique case (nibble)
            4'h0: seven_segments = 7'b1000000;
            4'h1: seven_segments = 7'b1111001;
            4'h2: seven_segments = 7'b0100100;
            4'h3: seven_segments = 7'b0110000;
            4'h4: seven_segments = 7'b0011001;
            4'h5: seven_segments = 7'b0010010;
            4'h6: seven_segments = 7'b0000010;
            4'h7: seven_segments = 7'b1111000;
            4'h8: seven_segments = 7'b0000000;
            4'h9: seven_segments = 7'b0010000;
            4'hA: seven_segments = 7'b0001000;
            4'hB: seven_segments = 7'b0000011;
            4'hC: seven_segments = 7'b1000110;
            4'hD: seven_segments = 7'b0100001;
            4'hE: seven_segments = 7'b0000110;
            4'hF: seven_segments = 7'b0001110;
            default: seven_segments = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_serial_transmitter_gen.sv
// Bench for serial_transmitter_gen: three instances (plain, parity, 6-bit length) on a shared
// clock and reset, each with its own SerIn/ClkPB.
module tb_serial_transmitter_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sin;
    logic [2:0] pb;
    logic [2:0] sout;
    logic [2:0] sval;
    logic [2:0] done;
    logic [6:0] seg0, seg1, seg2;

    int checks = 0;
    int errors = 0;
    int done_n [3] = '{0, 0, 0};

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic       sin;
        int         hold;
        logic       ev;
        logic       eo;
        logic [6:0] eseg;
        int         edone;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    serial_transmitter_gen #(.CNT_W(4), .START_LEVEL(1'b0), .PARITY_EN(1'b0), .SYNC_STAGES(2))
    u_dut0 (
        .clk(clk), .rst(rst), .SerIn(sin[0]), .ClkPB(pb[0]), .SerOut(sout[0]),
        .SerOutValid(sval[0]), .Done(done[0]), .seven_segments(seg0)
    );

    serial_transmitter_gen #(.CNT_W(4), .START_LEVEL(1'b0), .PARITY_EN(1'b1), .SYNC_STAGES(2))
    u_dut1 (
        .clk(clk), .rst(rst), .SerIn(sin[1]), .ClkPB(pb[1]), .SerOut(sout[1]),
        .SerOutValid(sval[1]), .Done(done[1]), .seven_segments(seg1)
    );

    serial_transmitter_gen #(.CNT_W(6), .START_LEVEL(1'b0), .PARITY_EN(1'b0), .SYNC_STAGES(3))
    u_dut2 (
        .clk(clk), .rst(rst), .SerIn(sin[2]), .ClkPB(pb[2]), .SerOut(sout[2]),
        .SerOutValid(sval[2]), .Done(done[2]), .seven_segments(seg2)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) done_n[i] <= done_n[i] + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Holds ClkPB high for 'hold' cycles then low for 3; SerIn stays stable throughout.
    task automatic press(input int d, input logic b, input int hold);
        @(negedge clk);
        sin[d] = b;
        pb[d]  = 1'b1;
        repeat (hold) @(negedge clk);
        pb[d] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_in(input int d, input logic b);
        @(negedge clk);
        sin[d] = b;
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int d);
        if (d == 0) return seg0;
        if (d == 1) return seg1;
        return seg2;
    endfunction

    initial begin
        logic [3:0] cbits;
        logic [5:0] cbits6;

        // REQ-032 frame, then a zero-length frame; expectations are before each press.
        vecs[0]  = '{1'b1, 3,  1'b0, 1'b0, 7'h40, 0};
        vecs[1]  = '{1'b0, 20, 1'b0, 1'b0, 7'h40, 0};
        vecs[2]  = '{1'b0, 3,  1'b0, 1'b0, 7'h40, 0};
        vecs[3]  = '{1'b0, 3,  1'b0, 1'b0, 7'h40, 0};
        vecs[4]  = '{1'b1, 3,  1'b0, 1'b0, 7'h40, 0};
        vecs[5]  = '{1'b1, 3,  1'b0, 1'b0, 7'h79, 0};
        vecs[6]  = '{1'b1, 3,  1'b1, 1'b1, 7'h30, 0};
        vecs[7]  = '{1'b0, 3,  1'b1, 1'b0, 7'h24, 0};
        vecs[8]  = '{1'b1, 3,  1'b1, 1'b1, 7'h79, 0};
        vecs[9]  = '{1'b1, 3,  1'b0, 1'b0, 7'h40, 1};
        vecs[10] = '{1'b0, 3,  1'b0, 1'b0, 7'h40, 1};
        vecs[11] = '{1'b0, 3,  1'b0, 1'b0, 7'h40, 1};
        vecs[12] = '{1'b0, 3,  1'b0, 1'b0, 7'h40, 1};
        vecs[13] = '{1'b0, 3,  1'b0, 1'b0, 7'h40, 1};
        vecs[14] = '{1'b0, 3,  1'b0, 1'b0, 7'h40, 1};
        vecs[15] = '{1'b1, 3,  1'b0, 1'b0, 7'h40, 2};

        rst = 1'b1;
        sin = '0;
        pb  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_valid%0d", d), 32'(sval[d]), 32'd0);
            chk($sformatf("reset_out%0d", d), 32'(sout[d]), 32'd0);
            chk($sformatf("reset_done%0d", d), 32'(done[d]), 32'd0);
            chk($sformatf("reset_seg%0d", d), 32'(seg_of(d)), 32'h40);
        end

        for (int i = 0; i < 16; i++) begin
            set_in(0, vecs[i].sin);
            chk($sformatf("vec%0d_valid", i), 32'(sval[0]), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_out", i), 32'(sout[0]), 32'(vecs[i].eo));
            chk($sformatf("vec%0d_seg", i), 32'(seg0), 32'(vecs[i].eseg));
            chk($sformatf("vec%0d_done", i), 32'(done_n[0]), 32'(vecs[i].edone));
            press(0, vecs[i].sin, vecs[i].hold);
        end

        // Reset mid-DATA with cnt=5 aborts the frame without Done.
        cbits = 4'b0101;
        press(0, 1'b0, 3);
        for (int k = 3; k >= 0; k--) press(0, cbits[k], 3);
        set_in(0, 1'b1);
        chk("rstdata_valid_pre", 32'(sval[0]), 32'd1);
        chk("rstdata_seg_pre", 32'(seg0), 32'h12);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstdata_valid", 32'(sval[0]), 32'd0);
        chk("rstdata_out", 32'(sout[0]), 32'd0);
        chk("rstdata_seg", 32'(seg0), 32'h40);
        repeat (5) @(negedge clk);
        chk("rstdata_nodone", 32'(done_n[0]), 32'd2);

        // Parity frames: count 2, data 1,1 then data 1,0.
        for (int f = 0; f < 2; f++) begin
            cbits = 4'b0010;
            press(1, 1'b0, 3);
            for (int k = 3; k >= 0; k--) press(1, cbits[k], 3);
            set_in(1, 1'b1);
            chk($sformatf("par%0d_d0_valid", f), 32'(sval[1]), 32'd1);
            chk($sformatf("par%0d_d0_seg", f), 32'(seg1), 32'h24);
            press(1, 1'b1, 3);
            set_in(1, (f == 0) ? 1'b1 : 1'b0);
            chk($sformatf("par%0d_d1_out", f), 32'(sout[1]), (f == 0) ? 32'd1 : 32'd0);
            chk($sformatf("par%0d_d1_seg", f), 32'(seg1), 32'h79);
            press(1, (f == 0) ? 1'b1 : 1'b0, 3);
            set_in(1, 1'b1);
            chk($sformatf("par%0d_p_valid", f), 32'(sval[1]), 32'd1);
            chk($sformatf("par%0d_p_out", f), 32'(sout[1]), (f == 0) ? 32'd0 : 32'd1);
            chk($sformatf("par%0d_p_done", f), 32'(done_n[1]), 32'(f));
            press(1, 1'b1, 3);
            #1;
            chk($sformatf("par%0d_end_valid", f), 32'(sval[1]), 32'd0);
            chk($sformatf("par%0d_end_done", f), 32'(done_n[1]), 32'(f + 1));
        end

        // Six-bit length field of 10: display counts A down to 1.
        cbits6 = 6'b001010;
        press(2, 1'b0, 3);
        for (int k = 5; k >= 0; k--) press(2, cbits6[k], 3);
        for (int k = 0; k < 10; k++) begin
            set_in(2, k[0]);
            chk($sformatf("w6_d%0d_valid", k), 32'(sval[2]), 32'd1);
            chk($sformatf("w6_d%0d_out", k), 32'(sout[2]), 32'(k[0]));
            chk($sformatf("w6_d%0d_seg", k), 32'(seg2), 32'(segtab[10 - k]));
            press(2, k[0], 3);
        end
        #1;
        chk("w6_end_valid", 32'(sval[2]), 32'd0);
        chk("w6_end_seg", 32'(seg2), 32'h40);
        chk("w6_end_done", 32'(done_n[2]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
